// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues word fetches over a valid/ready request port and
// holds the fetched word in an IF/ID register backed by a one-entry skid buffer.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [5:0]  opcode,
   output logic [5:0]  funct
);

   localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {StReq, StWait, StDrop} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_pc_q, out_pc_d;

   logic        req_fire;
   logic        deliver;
   logic        consume;
   logic        outstanding;
   logic [31:0] instr_out;

   // Gated by rst_n so the request line is low for the whole reset interval.
   assign imem_req_valid = rst_n && (state_q == StReq) && !skid_valid_q;
   assign imem_addr      = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign consume        = out_valid_q && !stall;
   // A response landing in the redirect cycle retires the outstanding request by itself.
   assign outstanding    = ((state_q == StWait) || (state_q == StDrop)) && !imem_resp_valid;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      deliver  = 1'b0;
      if (redirect_valid) begin
         pc_d = {redirect_pc[31:2], 2'b00};
         if (req_fire || outstanding) begin
            state_d = StDrop;
         end else begin
            state_d = StReq;
         end
      end else begin
         unique case (state_q)
            StReq: begin
               if (req_fire) begin
                  pc_d     = pc_q + PC_STEP;
                  req_pc_d = pc_q;
                  state_d  = StWait;
               end
            end
            StWait: begin
               if (imem_resp_valid) begin
                  deliver = 1'b1;
                  state_d = StReq;
               end
            end
            StDrop: begin
               if (imem_resp_valid) begin
                  state_d = StReq;
               end
            end
            default: state_d = StReq;
         endcase
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_pc_d     = out_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if (redirect_valid) begin
         out_valid_d  = 1'b0;
         out_instr_d  = 32'h0;
         skid_valid_d = 1'b0;
      end else if (consume) begin
         if (skid_valid_q) begin
            out_instr_d  = skid_instr_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = deliver;
            if (deliver) begin
               skid_instr_d = imem_resp_data;
               skid_pc_d    = req_pc_q;
            end
         end else if (deliver) begin
            out_instr_d = imem_resp_data;
            out_pc_d    = req_pc_q;
         end else begin
            out_valid_d = 1'b0;
            out_instr_d = 32'h0;
         end
      end else if (deliver) begin
         if (!out_valid_q) begin
            out_valid_d = 1'b1;
            out_instr_d = imem_resp_data;
            out_pc_d    = req_pc_q;
         end else begin
            // Output is held by stall; park the word so it is not lost.
            skid_valid_d = 1'b1;
            skid_instr_d = imem_resp_data;
            skid_pc_d    = req_pc_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StReq;
         pc_q         <= ResetPcAligned;
         req_pc_q     <= 32'h0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= 32'h0;
         skid_pc_q    <= 32'h0;
         out_valid_q  <= 1'b0;
         out_instr_q  <= 32'h0;
         out_pc_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_pc_q     <= out_pc_d;
      end
   end

   // Invalid output reads as all-zero, which the decoder treats as sll $0 (a NOP).
   assign instr_out   = out_valid_q ? out_instr_q : 32'h0;
   assign if_valid    = out_valid_q;
   assign if_instr    = instr_out;
   assign if_pc       = out_valid_q ? out_pc_q : 32'h0;
   assign if_pc_plus4 = out_valid_q ? (out_pc_q + 32'd4) : 32'h0;
   assign opcode      = instr_out[31:26];
   assign funct       = instr_out[5:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a one-outstanding memory model with a response
// enable, plus a second instance whose reset PC sits at the top of the address space.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [5:0]  opcode;
   logic [5:0]  funct;

   logic        w_req_valid;
   logic [31:0] w_addr;
   logic        w_resp_valid;
   logic [31:0] w_resp_data;
   logic        w_if_valid;
   logic [31:0] w_if_instr;
   logic [31:0] w_if_pc;
   logic [31:0] w_if_pc_plus4;
   logic [5:0]  w_opcode;
   logic [5:0]  w_funct;

   logic        resp_en = 1'b1;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   logic        w_pend = 1'b0;
   logic [31:0] w_pend_addr = 32'h0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h2008_0005 : {8'hA5, a[23:0]};
   endfunction

   always @(posedge clk) begin
      if (imem_req_valid && imem_req_ready) begin
         pend      <= 1'b1;
         pend_addr <= imem_addr;
      end else if (imem_resp_valid) begin
         pend <= 1'b0;
      end
      w_pend      <= w_req_valid;
      w_pend_addr <= w_addr;
   end

   assign imem_resp_valid = pend && resp_en;
   assign imem_resp_data  = mem_word(pend_addr);
   assign w_resp_valid    = w_pend;
   assign w_resp_data     = mem_word(w_pend_addr);

   instruction_fetch_unit u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .if_valid        (if_valid),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_pc_plus4     (if_pc_plus4),
      .opcode          (opcode),
      .funct           (funct)
   );

   instruction_fetch_unit #(
      .RESET_PC (32'hFFFF_FFFF)
   ) u_dut_wrap (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (w_req_valid),
      .imem_req_ready  (1'b1),
      .imem_addr       (w_addr),
      .imem_resp_valid (w_resp_valid),
      .imem_resp_data  (w_resp_data),
      .stall           (1'b0),
      .redirect_valid  (1'b0),
      .redirect_pc     (32'h0),
      .if_valid        (w_if_valid),
      .if_instr        (w_if_instr),
      .if_pc           (w_if_pc),
      .if_pc_plus4     (w_if_pc_plus4),
      .opcode          (w_opcode),
      .funct           (w_funct)
   );

   task automatic test_reset();
      @(negedge clk);
      #1;
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
      vectors++; if (if_instr !== 32'h0) begin miscompares++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
      vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
      vectors++; if (if_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL rst_pc_plus4: got %h want 0", if_pc_plus4); end
      vectors++; if ({opcode, funct} !== 12'h0) begin miscompares++; $display("FAIL rst_opc_funct: got %h/%h want 0/0", opcode, funct); end
      vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL first_req: got %b/%h want 1/00000000", imem_req_valid, imem_addr); end
      @(negedge clk);
      vectors++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL wait_cycle: got req %b if_valid %b want 0/0", imem_req_valid, if_valid); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h2008_0005) begin miscompares++; $display("FAIL first_instr: got %b %h %h want 1 00000000 20080005", if_valid, if_pc, if_instr); end
      vectors++; if (opcode !== 6'h08 || funct !== 6'h05 || if_pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL first_decode: got %h %h %h want 08 05 00000004", opcode, funct, if_pc_plus4); end
      vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL second_req: got %b/%h want 1/00000004", imem_req_valid, imem_addr); end
   endtask

   task automatic test_stall();
      @(negedge clk);
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL consumed_gap: got %b want 0", if_valid); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'hA500_0004) begin miscompares++; $display("FAIL instr_4: got %b %h %h want 1 00000004 a5000004", if_valid, if_pc, if_instr); end
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'hA500_0004) begin miscompares++; $display("FAIL stall_hold[%0d]: got %b %h %h want 1 00000004 a5000004", i, if_valid, if_pc, if_instr); end
         vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL stall_no_req[%0d]: got %b want 0", i, imem_req_valid); end
      end
      stall = 1'b0;
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'hA500_0008) begin miscompares++; $display("FAIL skid_out: got %b %h %h want 1 00000008 a5000008", if_valid, if_pc, if_instr); end
      vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin miscompares++; $display("FAIL req_c: got %b/%h want 1/0000000c", imem_req_valid, imem_addr); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL post_skid_gap: got %b want 0", if_valid); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_pc_plus4 !== 32'h10) begin miscompares++; $display("FAIL instr_c: got %b %h %h want 1 0000000c 00000010", if_valid, if_pc, if_pc_plus4); end
      vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL req_10: got %b/%h want 1/00000010", imem_req_valid, imem_addr); end
   endtask

   task automatic test_redirect_wait();
      resp_en = 1'b0;
      @(negedge clk);
      vectors++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL in_wait: got req %b if_valid %b want 0/0", imem_req_valid, if_valid); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      @(negedge clk);
      redirect_valid = 1'b0;
      vectors++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL drop_state: got req %b if_valid %b want 0/0", imem_req_valid, if_valid); end
      resp_en = 1'b1;
      @(negedge clk);
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL stale_discard: got %b pc %h want 0", if_valid, if_pc); end
      vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL req_target: got %b/%h want 1/00000100", imem_req_valid, imem_addr); end
      @(negedge clk);
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hA500_0100) begin miscompares++; $display("FAIL target_instr: got %b %h %h want 1 00000100 a5000100", if_valid, if_pc, if_instr); end
   endtask

   task automatic test_redirect_same_cycle();
      @(negedge clk);
      vectors++; if (imem_resp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL setup_same: got resp %b req %b want 1/0", imem_resp_valid, imem_req_valid); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      @(negedge clk);
      redirect_valid = 1'b0;
      vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL same_req_next: got %b/%h want 1/00000200", imem_req_valid, imem_addr); end
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL same_flush: got %b want 0", if_valid); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL same_resp_dropped: got %b pc %h want 0", if_valid, if_pc); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_pc_plus4 !== 32'h204) begin miscompares++; $display("FAIL same_target: got %b %h %h want 1 00000200 00000204", if_valid, if_pc, if_pc_plus4); end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++; if (w_if_valid !== 1'b0 || w_req_valid !== 1'b0 || w_if_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_rst: got %b %b %h want 0 0 00000000", w_if_valid, w_req_valid, w_if_pc_plus4); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++; if (w_req_valid !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_first_req: got %b/%h want 1/fffffffc", w_req_valid, w_addr); end
      @(negedge clk);
      @(negedge clk);
      vectors++; if (w_if_valid !== 1'b1 || w_if_pc !== 32'hFFFF_FFFC || w_if_instr !== 32'hA5FF_FFFC) begin miscompares++; $display("FAIL wrap_instr: got %b %h %h want 1 fffffffc a5fffffc", w_if_valid, w_if_pc, w_if_instr); end
      vectors++; if (w_if_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_plus4: got %h want 00000000", w_if_pc_plus4); end
      vectors++; if (w_req_valid !== 1'b1 || w_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next_req: got %b/%h want 1/00000000", w_req_valid, w_addr); end
      @(negedge clk);
      @(negedge clk);
      vectors++; if (w_if_valid !== 1'b1 || w_if_pc !== 32'h0 || w_opcode !== 6'h08) begin miscompares++; $display("FAIL wrap_zero_instr: got %b %h %h want 1 00000000 08", w_if_valid, w_if_pc, w_opcode); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst_n   = 1'b0;
      resp_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL mid_setup: got %b %h addr %h want 1 00000000 00000004", if_valid, if_pc, imem_addr); end
      resp_en = 1'b0;
      @(negedge clk);
      vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL mid_wait: got %b want 0", imem_req_valid); end
      rst_n = 1'b0;
      #1;
      vectors++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL mid_rst_out: got %b %h %h %h want 0 0 0 0", if_valid, if_instr, if_pc, if_pc_plus4); end
      vectors++; if (opcode !== 6'h0 || funct !== 6'h0 || imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_rst_if: got %h %h %b %h want 00 00 0 00000000", opcode, funct, imem_req_valid, imem_addr); end
      @(negedge clk);
      rst_n   = 1'b1;
      resp_en = 1'b1;
      #1;
      vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_refetch: got %b/%h want 1/00000000", imem_req_valid, imem_addr); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stray: got %b instr %h want 0", if_valid, if_instr); end
      @(negedge clk);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h2008_0005) begin miscompares++; $display("FAIL mid_first: got %b %h %h want 1 00000000 20080005", if_valid, if_pc, if_instr); end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect_wait();
      test_redirect_same_cycle();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the opcode/ALU control decoder.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request and valid response interface.
- Holds the fetched instruction in an IF/ID output register with a one-entry skid buffer, and honours stall and redirect (jump/branch/jr) requests.
- Presents opcode[31:26] and funct[5:0] to the decoder.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset. Bits [1:0] are ignored (forced 0).
- PC_STEP, 4, increment applied to the PC on each accepted request.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  fetch address. Always equals the PC; bits [1:0] are always 0.
- imem_resp_valid  in  1  response data valid. Arrives at least 1 cycle after acceptance.
- imem_resp_data  in  32  fetched instruction word.
- stall  in  1  downstream cannot consume the instruction in the output register.
- redirect_valid  in  1  one-cycle pulse: flush and continue fetching at redirect_pc.
- redirect_pc  in  32  redirect target. Bits [1:0] are forced to 0.
- if_valid  out  1  output register holds a valid instruction.
- if_instr  out  32  instruction word (32'h0 when invalid).
- if_pc  out  32  address of if_instr.
- if_pc_plus4  out  32  if_pc + 4 (link value for jal/jalr).
- opcode  out  6  if_instr[31:26]; 0 when if_valid=0.
- funct  out  6  if_instr[5:0]; 0 when if_valid=0.

Behaviour:
- **Reset.** Reset is asynchronous and active-low. While rst_n=0:
  - pc=RESET_PC, state=REQ, skid empty.
  - if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, opcode=0, funct=0, imem_req_valid=0.
  - Because opcode=0/funct=0 is decoded as sll $0 (a NOP), the decoder sees a NOP.
- **FSM states:**
  - REQ: imem_req_valid = skid_empty.
    - On valid&&ready: pc <= pc+PC_STEP, go to WAIT, latch req_pc.
  - WAIT: imem_req_valid=0. At most one request is ever outstanding.
    - On imem_resp_valid: deliver {imem_resp_data, req_pc}, go to REQ.
  - DROP: entered when a redirect occurs while a request is outstanding (WAIT, or REQ in the same cycle as acceptance).
    - The next imem_resp_valid is discarded, then go to REQ.
- **Request timing.** The first request is asserted in the first cycle after rst_n deasserts, with addr=RESET_PC.
- **Delivery.**
  - Consume condition: if_valid && !stall.
  - A delivered word loads the output register if the register is empty or being consumed that cycle. Otherwise it loads the skid buffer.
  - On consume: output <= skid if the skid is full (skid empties). Otherwise output <= the delivered word this cycle. Otherwise if_valid <= 0.
  - No new request is issued while the skid is full, so no word is ever lost.
- **Latency.** Response in cycle N means if_valid=1 in cycle N+1 (registered). With a 1-cycle memory and no stall, throughput is one instruction per 2 cycles.
- **Redirect priority.** Redirect has highest priority, over stall, delivery and consumption. In that cycle:
  - pc <= {redirect_pc[31:2],2'b00}.
  - if_valid <= 0, skid cleared.
  - State goes to DROP if a request is outstanding or accepted that cycle, else REQ.
  - A response arriving in the same cycle as the redirect is discarded, and DROP is not entered for it.
  - The first post-redirect request is issued the cycle after the redirect.
- **Redirect vs. in-flight request.** A request that is valid but not yet accepted when a redirect arrives may be withdrawn. Its address changes to the new PC in the next cycle.
- **Address stability.** imem_addr is stable while imem_req_valid=1 and !imem_req_ready, except on a redirect.
- **Stray responses.** An imem_resp_valid in state REQ is ignored.
- **Arithmetic.** The PC is 32-bit and wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0, with no error.
- **Stall.** stall holds if_instr, if_pc and if_valid unchanged. stall with if_valid=0 has no effect.
- **Reset mid-operation.** Asserting rst_n at any time returns the block to the reset state immediately. Outstanding responses arriving after reset release, while in state REQ, are ignored.

Test Plan:
1. Reset release, memory ready=1, 1-cycle response returning 32'h2008_0005 at 0x0 → imem_addr=0x0 in cycle 1, if_valid=1 with if_pc=0, opcode=6'h08, if_pc_plus4=4. Next request addr=0x4.
2. stall=1 for 5 cycles while if_valid=1 with instr at 0x4 → output held. The 0x8 word goes to the skid; no request for 0xC until stall drops. Then 0x8 and 0xC appear in order.
3. Redirect to 0x0000_0103 while in WAIT for 0x10 → the 0x10 response is discarded, if_valid=0. Next request addr=0x100 and if_pc=0x100 is delivered.
4. Redirect and imem_resp_valid in the same cycle → the response is dropped, no DROP state is entered, and a request to the target is issued the next cycle.
5. RESET_PC=32'hFFFF_FFFC → the fetch at 0xFFFF_FFFC is followed by a fetch at 0x0. if_pc_plus4=0 for the first instruction.
6. rst_n pulsed low during WAIT while a response is returned after release → all outputs are 0 during reset, the stray response is ignored, and refetch starts at RESET_PC.
